// File: rtl/matrix_scalar_div_pkg.sv
// rtl/matrix_scalar_div_pkg.sv - default geometry, FSM states and element packing helper for matrix_scalar_div
package matrix_scalar_div_pkg;

  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 2;
  localparam int DEF_W    = 4;
  localparam int DEF_FRAC = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_STORE,
    S_DONE
  } state_t;

  // LSB position of element k in a row-major pack with element 0 at the MSBs
  function automatic int elem_lsb(input int n, input int w, input int k);
    return (n - 1 - k) * w;
  endfunction

endpackage

// File: rtl/matrix_scalar_div_serial_div_unsigned.sv
// rtl/matrix_scalar_div_serial_div_unsigned.sv - unsigned restoring divider, one quotient bit per cycle
module serial_div_unsigned #(
  parameter int DW = 5,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          rdy
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] r_q;
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [VW:0]   w_trial;

  // Partial remainder stays below the divisor, so the shifted value fits VW+1 bits
  assign w_trial = {r_rem, r_q[DW-1]} - {1'b0, r_div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (go) begin
      r_q   <= dividend;
      r_rem <= '0;
      r_div <= divisor;
      r_cnt <= CW'(DW);
    end else if (r_cnt != '0) begin
      r_rem <= w_trial[VW] ? {r_rem[VW-2:0], r_q[DW-1]} : w_trial[VW-1:0];
      r_q   <= {r_q[DW-2:0], ~w_trial[VW]};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign quotient  = r_q;
  assign remainder = r_rem;
  assign rdy       = (r_cnt == '0);

endmodule

// File: rtl/matrix_scalar_div.sv
// rtl/matrix_scalar_div.sv - serial element-wise signed fixed-point matrix / scalar divider (MATRIX_DIV_ROUND_EN: round half away from zero)
module matrix_scalar_div
  import matrix_scalar_div_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROWS*COLS*W-1:0] A,
  input  logic [W-1:0]           a,
  output logic                   busy,
  output logic                   done,
  output logic [ROWS*COLS*W-1:0] B,
  output logic                   div_zero
);
  localparam int N  = ROWS * COLS;
  localparam int DW = W + FRAC;
  localparam int VW = W + 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(DW + 1);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  state_t          r_state, w_next;
  logic [KW-1:0]   r_k;
  logic [SW-1:0]   r_step;
  logic [N*W-1:0]  r_A, r_B;
  logic [W-1:0]    r_a;
  logic            r_dz;

  logic [W-1:0]    w_elem, w_res;
  logic [VW-1:0]   w_e_ext, w_a_ext, w_mag_e, w_mag_a, w_rem;
  logic [DW-1:0]   w_dividend, w_quot;
  logic [DW:0]     w_mag_q;
  logic            w_rdy, w_go, w_neg, w_inc;

  assign w_elem     = r_A[elem_lsb(N, W, int'(r_k)) +: W];
  assign w_e_ext    = {w_elem[W-1], w_elem};
  assign w_a_ext    = {r_a[W-1], r_a};
  assign w_mag_e    = w_e_ext[VW-1] ? -w_e_ext : w_e_ext;
  assign w_mag_a    = w_a_ext[VW-1] ? -w_a_ext : w_a_ext;
  assign w_dividend = DW'(w_mag_e) << FRAC;
  assign w_neg      = w_elem[W-1] ^ r_a[W-1];
  assign w_go       = (r_state == S_LOAD);

  serial_div_unsigned #(.DW(DW), .VW(VW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .go        (w_go),
    .dividend  (w_dividend),
    .divisor   (w_mag_a),
    .quotient  (w_quot),
    .remainder (w_rem),
    .rdy       (w_rdy)
  );

`ifdef MATRIX_DIV_ROUND_EN
  assign w_inc = ({w_rem, 1'b0} >= {1'b0, w_mag_a});
`else
  assign w_inc = 1'b0;
  logic w_unused_rem;
  assign w_unused_rem = ^w_rem;
`endif

  assign w_mag_q = {1'b0, w_quot} + (DW+1)'(w_inc);

  // Sign, saturation and the divide-by-zero override
  always_comb begin
    w_res = '0;
    if (r_dz) begin
      if (w_elem[W-1])  w_res = MIN_V;
      else if (|w_elem) w_res = MAX_V;
    end else if (!w_neg) begin
      w_res = (w_mag_q > (DW+1)'(MAX_V)) ? MAX_V : w_mag_q[W-1:0];
    end else begin
      w_res = (w_mag_q > (DW+1)'(2**(W-1))) ? MIN_V : W'(-w_mag_q);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_DIV;
      S_DIV:   if (r_step == SW'(DW - 1)) w_next = S_STORE;
      S_STORE: w_next = (r_k == KW'(N - 1)) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_step  <= '0;
      r_A     <= '0;
      r_a     <= '0;
      r_B     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_A  <= A;
          r_a  <= a;
          r_dz <= 1'b0;
          r_k  <= '0;
        end
        S_LOAD: begin
          r_step <= '0;
          if (r_k == '0) r_dz <= (r_a == '0);
        end
        S_DIV: r_step <= r_step + 1'b1;
        S_STORE: if (w_rdy) begin
          r_B[elem_lsb(N, W, int'(r_k)) +: W] <= w_res;
          r_k <= (r_k == KW'(N - 1)) ? '0 : r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_LOAD) || (r_state == S_DIV) || (r_state == S_STORE);
  assign done     = (r_state == S_DONE);
  assign B        = r_B;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_matrix_scalar_div.sv
// tb/tb_matrix_scalar_div.sv - scoreboard bench for matrix_scalar_div against an integer-arithmetic model
module tb_matrix_scalar_div;
  localparam int N    = 6;
  localparam int W    = 4;
  localparam int FRAC = 1;
  localparam int AW   = N * W;
  localparam int LAT  = 42;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] A = '0;
  logic [W-1:0]  a = '0;
  logic          busy, done, div_zero;
  logic [AW-1:0] B;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0] b;
    logic          dz;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  matrix_scalar_div dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .a        (a),
    .busy     (busy),
    .done     (done),
    .B        (B),
    .div_zero (div_zero)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [AW-1:0] pk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4, input int e5);
    return {W'(e0), W'(e1), W'(e2), W'(e3), W'(e4), W'(e5)};
  endfunction

  // Quotient = A*2^FRAC / a in plain integer arithmetic, then clipped to the W-bit range
  function automatic exp_t model(input logic [AW-1:0] av, input logic [W-1:0] sv);
    exp_t r;
    logic signed [W-1:0] e, d;
    int x, y, num, q;
`ifdef MATRIX_DIV_ROUND_EN
    int rem;
`endif
    d = sv;
    y = d;
    r.dz = (y == 0);
    r.b = '0;
    for (int k = 0; k < N; k++) begin
      e = av[(N-1-k)*W +: W];
      x = e;
      num = x * (2 ** FRAC);
      if (y == 0) q = (x > 0) ? 7 : ((x < 0) ? -8 : 0);
      else begin
        q = num / y;
`ifdef MATRIX_DIV_ROUND_EN
        rem = num % y;
        if (2 * (rem < 0 ? -rem : rem) >= (y < 0 ? -y : y))
          q += ((num < 0) != (y < 0)) ? -1 : 1;
`endif
      end
      if (q > 7) q = 7;
      if (q < -8) q = -8;
      r.b[(N-1-k)*W +: W] = q[W-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("B", B, e.b);
        check("div_zero", div_zero, e.dz);
      end
    end
  end

  task automatic run_op(input logic [AW-1:0] av, input logic [W-1:0] sv,
                        input int pulse_at, input logic [AW-1:0] alt);
    int got;
    bit busy_ok;
    repeat (2) @(negedge clk);
    A = av;
    a = sv;
    start = 1'b1;
    exp_q.push_back(model(av, sv));
    @(posedge clk);
    #1;
    start = 1'b0;
    A = AW'($urandom);
    check("div_zero_cleared_at_start", div_zero, 0);
    got = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      if (n == pulse_at) begin
        A = alt;
        a = ~sv;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        got = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check("latency", got, LAT);
    check("busy_during_op", busy_ok, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic abort_op(input logic [AW-1:0] av, input logic [W-1:0] sv);
    int dones;
    repeat (2) @(negedge clk);
    A = av;
    a = sv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_B", B, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_B", B, 0);
    rst = 1'b0;

    run_op(pk(4, 4, 4, 4, 4, 4), W'(2), 0, '0);
    run_op(pk(-6, 1, 2, 3, -1, 0), W'(3), 0, '0);
    run_op(pk(0, 5, -7, 7, -8, 2), W'(-4), 0, '0);
    run_op(pk(1, 2, 5, -5, 6, -3), W'(3), 0, '0);
    run_op(pk(7, -8, -1, 0, 1, -7), W'(1), 0, '0);
    run_op(pk(-8, -8, 7, -7, 1, -1), W'(-8), 0, '0);
    run_op(pk(-8, 7, 3, -3, 6, -6), W'(-1), 0, '0);
    run_op(pk(3, -2, 0, 3, -2, 0), W'(0), 0, '0);
    run_op(pk(3, -2, 0, 3, -2, 0), W'(2), 0, '0);
    abort_op(pk(5, -5, 6, -6, 7, -7), W'(3));
    run_op(pk(5, -5, 6, -6, 7, -7), W'(3), 0, '0);
    run_op(pk(1, 3, 5, 7, -3, -7), W'(3), 10, pk(-8, -8, -8, -8, -8, -8));
    repeat (30) run_op(AW'($urandom), W'($urandom), 0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
